// File: rtl/branch_hazard_unit.sv
// branch_hazard_unit: BHT branch prediction, mispredict flush, load-use stall and perf counters
module branch_hazard_unit #(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 16,
    parameter logic [1:0] CTR_INIT    = 2'b01,
    parameter int         CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    input  logic             ex_branch,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_taken,
    input  logic             ex_pred_taken,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    output logic             mispredict,
    output logic             if_flush,
    output logic             id_flush,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             id_bubble,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [BHT_ENTRIES-1:0][1:0] bht_q, bht_d;
    logic [IDX_W-1:0]            if_idx, ex_idx;
    logic [1:0]                  ex_ctr;
    logic                        hz;
    logic                        unused_pc;
    logic [CNT_W-1:0]            branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]            mispred_cnt_q, mispred_cnt_d;
    logic [CNT_W-1:0]            stall_cnt_q, stall_cnt_d;

    // Word-aligned index; PC bits outside the index field do not affect lookup
    always_comb begin
        if_idx    = if_pc[IDX_W+1:2];
        ex_idx    = ex_pc[IDX_W+1:2];
        unused_pc = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0], ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};
    end

    // Prediction reads the registered table, so a same-index update is seen next cycle; mispredict beats load-use
    always_comb begin
        if_pred_taken = bht_q[if_idx][1];
        mispredict    = ex_branch && (ex_taken != ex_pred_taken);
        hz            = idex_mem_read && (idex_rd != 5'd0) &&
                        ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
        if_flush      = mispredict;
        id_flush      = mispredict;
        id_bubble     = hz && !mispredict;
        pc_write_en   = !id_bubble;
        ifid_write_en = !id_bubble;
    end

    // Saturating counter training on resolved branches and wrapping event counters
    always_comb begin
        ex_ctr = bht_q[ex_idx];
        bht_d  = bht_q;
        if (ex_branch)
            bht_d[ex_idx] = ex_taken ? ((ex_ctr == 2'b11) ? ex_ctr : ex_ctr + 2'd1)
                                     : ((ex_ctr == 2'b00) ? ex_ctr : ex_ctr - 2'd1);
        branch_cnt_d  = branch_cnt_q + CNT_W'(ex_branch);
        mispred_cnt_d = mispred_cnt_q + CNT_W'(mispredict);
        stall_cnt_d   = stall_cnt_q + CNT_W'(id_bubble);
    end

    // State registers with synchronous reset that overrides any pending update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bht_q         <= {BHT_ENTRIES{CTR_INIT}};
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            bht_q         <= bht_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
    assign stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_branch_hazard_unit.sv
// tb_branch_hazard_unit: directed self-checking bench for branch_hazard_unit
module tb_branch_hazard_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc, ex_pc;
    logic        ex_branch, ex_taken, ex_pred_taken, idex_mem_read;
    logic [4:0]  idex_rd, ifid_rs1, ifid_rs2;
    logic        if_pred_taken, mispredict, if_flush, id_flush;
    logic        pc_write_en, ifid_write_en, id_bubble;
    logic [31:0] branch_cnt, mispred_cnt, stall_cnt;
    logic        w_pred, w_mis, w_iff, w_idf, w_pcw, w_ifw, w_bub;
    logic [3:0]  w_branch_cnt, w_mispred_cnt, w_stall_cnt;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    branch_hazard_unit dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_branch(ex_branch), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .mispredict(mispredict), .if_flush(if_flush), .id_flush(id_flush),
        .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en), .id_bubble(id_bubble),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt), .stall_cnt(stall_cnt)
    );

    // narrow-counter copy so wrap-around is reachable in a short run
    branch_hazard_unit #(.CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(w_pred),
        .ex_branch(ex_branch), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .mispredict(w_mis), .if_flush(w_iff), .id_flush(w_idf),
        .pc_write_en(w_pcw), .ifid_write_en(w_ifw), .id_bubble(w_bub),
        .branch_cnt(w_branch_cnt), .mispred_cnt(w_mispred_cnt), .stall_cnt(w_stall_cnt)
    );

    task automatic idle();
        ex_branch = 0; ex_taken = 0; ex_pred_taken = 0; ex_pc = 0;
        idex_mem_read = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; idle(); if_pc = 32'h40;
        tick(); tick();
        #1;
        checks++;
        if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred got=%b exp=0", if_pred_taken); end
        checks++;
        if ({mispredict, if_flush, id_flush, pc_write_en, ifid_write_en, id_bubble} !== 6'b000110) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=000110", {mispredict, if_flush, id_flush, pc_write_en, ifid_write_en, id_bubble});
        end
        checks++;
        if ({branch_cnt, mispred_cnt, stall_cnt} !== 96'd0) begin
            failures++; $display("FAIL reset_cnt got=%h/%h/%h exp=0", branch_cnt, mispred_cnt, stall_cnt);
        end
        rst_n = 1;
        tick();
    endtask

    task automatic test_bht_train();
        ex_branch = 1; ex_pc = 32'h40; ex_taken = 1; ex_pred_taken = 1; if_pc = 32'h40;
        #1;
        checks++;
        if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL train_pre got=%b exp=0", if_pred_taken); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (if_pred_taken !== 1'b1) begin failures++; $display("FAIL train_edge%0d got=%b exp=1", i, if_pred_taken); end
        end
        idle();
        checks++;
        if (branch_cnt !== 32'd3) begin failures++; $display("FAIL train_branch_cnt got=%0d exp=3", branch_cnt); end
        if_pc = 32'h44;
        #1;
        checks++;
        if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL train_other_idx got=%b exp=0", if_pred_taken); end
    endtask

    task automatic test_mispredict();
        ex_branch = 1; ex_pc = 32'h44; ex_pred_taken = 0; ex_taken = 1;
        #1;
        checks++;
        if ({mispredict, if_flush, id_flush} !== 3'b111) begin
            failures++; $display("FAIL mis_flush got=%b exp=111", {mispredict, if_flush, id_flush});
        end
        tick();
        ex_taken = 0;
        #1;
        checks++;
        if ({mispredict, if_flush, id_flush} !== 3'b000) begin
            failures++; $display("FAIL mis_correct got=%b exp=000", {mispredict, if_flush, id_flush});
        end
        checks++;
        if (mispred_cnt !== 32'd1) begin failures++; $display("FAIL mis_cnt got=%0d exp=1", mispred_cnt); end
        tick();
        idle(); ex_taken = 1;
        #1;
        checks++;
        if (mispredict !== 1'b0) begin failures++; $display("FAIL mis_no_branch got=%b exp=0", mispredict); end
        checks++;
        if (branch_cnt !== 32'd5 || mispred_cnt !== 32'd1) begin
            failures++; $display("FAIL mis_totals got=%0d/%0d exp=5/1", branch_cnt, mispred_cnt);
        end
        idle();
    endtask

    task automatic test_load_use();
        idex_mem_read = 1; idex_rd = 5; ifid_rs1 = 0; ifid_rs2 = 5;
        #1;
        checks++;
        if ({pc_write_en, ifid_write_en, id_bubble} !== 3'b001) begin
            failures++; $display("FAIL lu_rs2 got=%b exp=001", {pc_write_en, ifid_write_en, id_bubble});
        end
        tick();
        ifid_rs1 = 5; ifid_rs2 = 0;
        #1;
        checks++;
        if ({pc_write_en, ifid_write_en, id_bubble} !== 3'b001 || stall_cnt !== 32'd1) begin
            failures++; $display("FAIL lu_rs1 got=%b cnt=%0d exp=001 cnt=1", {pc_write_en, ifid_write_en, id_bubble}, stall_cnt);
        end
        tick();
        idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
        #1;
        checks++;
        if ({pc_write_en, ifid_write_en, id_bubble} !== 3'b110 || stall_cnt !== 32'd2) begin
            failures++; $display("FAIL lu_rd0 got=%b cnt=%0d exp=110 cnt=2", {pc_write_en, ifid_write_en, id_bubble}, stall_cnt);
        end
        idex_mem_read = 0; idex_rd = 9; ifid_rs1 = 9;
        #1;
        checks++;
        if (id_bubble !== 1'b0) begin failures++; $display("FAIL lu_no_load got=%b exp=0", id_bubble); end
        tick();
        checks++;
        if (stall_cnt !== 32'd2) begin failures++; $display("FAIL lu_cnt_hold got=%0d exp=2", stall_cnt); end
        idle();
    endtask

    task automatic test_priority();
        idex_mem_read = 1; idex_rd = 7; ifid_rs1 = 7;
        ex_branch = 1; ex_pc = 32'h48; ex_pred_taken = 1; ex_taken = 0;
        #1;
        checks++;
        if ({if_flush, id_flush, pc_write_en, ifid_write_en, id_bubble} !== 5'b11110) begin
            failures++; $display("FAIL prio_ctrl got=%b exp=11110", {if_flush, id_flush, pc_write_en, ifid_write_en, id_bubble});
        end
        tick();
        idle();
        checks++;
        if (stall_cnt !== 32'd2 || mispred_cnt !== 32'd2 || branch_cnt !== 32'd6) begin
            failures++; $display("FAIL prio_cnt got=%0d/%0d/%0d exp=2/2/6", stall_cnt, mispred_cnt, branch_cnt);
        end
    endtask

    task automatic test_same_index();
        ex_branch = 1; ex_pc = 32'h80; ex_taken = 0; ex_pred_taken = 0;
        tick(); tick();
        if_pc = 32'h80; ex_taken = 1;
        #1;
        checks++;
        if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL same_idx_now got=%b exp=0", if_pred_taken); end
        tick();
        idle();
        #1;
        checks++;
        if (if_pred_taken !== 1'b1) begin failures++; $display("FAIL same_idx_next got=%b exp=1", if_pred_taken); end
        if_pc = 32'hC0;
        #1;
        checks++;
        if (if_pred_taken !== 1'b1) begin failures++; $display("FAIL alias_c0 got=%b exp=1", if_pred_taken); end
        if_pc = 32'h84;
        #1;
        checks++;
        if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL idx1_pred got=%b exp=0", if_pred_taken); end
        checks++;
        if (branch_cnt !== 32'd9 || mispred_cnt !== 32'd3) begin
            failures++; $display("FAIL same_idx_cnt got=%0d/%0d exp=9/3", branch_cnt, mispred_cnt);
        end
    endtask

    task automatic test_wrap_and_reset();
        ex_branch = 1; ex_pc = 32'h4C; ex_pred_taken = 0; ex_taken = 1;
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if (w_mispred_cnt !== 4'hF) begin failures++; $display("FAIL wrap_pre got=%h exp=f", w_mispred_cnt); end
        tick();
        checks++;
        if (w_mispred_cnt !== 4'h0 || mispred_cnt !== 32'd16) begin
            failures++; $display("FAIL wrap got=%h/%0d exp=0/16", w_mispred_cnt, mispred_cnt);
        end
        checks++;
        if (w_branch_cnt !== 4'd6 || branch_cnt !== 32'd22) begin
            failures++; $display("FAIL wrap_branch got=%0d/%0d exp=6/22", w_branch_cnt, branch_cnt);
        end
        if_pc = 32'h4C;
        #1;
        checks++;
        if (if_pred_taken !== 1'b1) begin failures++; $display("FAIL idx3_trained got=%b exp=1", if_pred_taken); end
        rst_n = 0; ex_pc = 32'h40;
        tick();
        rst_n = 1; idle();
        #1;
        checks++;
        if ({branch_cnt, mispred_cnt, stall_cnt, w_branch_cnt, w_mispred_cnt} !== 104'd0) begin
            failures++; $display("FAIL midrst_cnt got=%0d/%0d/%0d/%0d/%0d exp=0", branch_cnt, mispred_cnt, stall_cnt, w_branch_cnt, w_mispred_cnt);
        end
        checks++;
        if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL midrst_idx3 got=%b exp=0", if_pred_taken); end
        ex_branch = 1; ex_pc = 32'h40; ex_taken = 1; ex_pred_taken = 1; if_pc = 32'h40;
        tick();
        idle();
        #1;
        checks++;
        if (if_pred_taken !== 1'b1 || branch_cnt !== 32'd1) begin
            failures++; $display("FAIL midrst_init got=%b/%0d exp=1/1", if_pred_taken, branch_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_bht_train();
        test_mispredict();
        test_load_use();
        test_priority();
        test_same_index();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
